// File: rtl/tl_ul_sram_responder.sv
// rtl/tl_ul_sram_responder.sv - TL-UL manager terminating A and answering from a 64-bit word SRAM
module tl_ul_sram_responder #(
    parameter logic [28:0] BASE_ADDR   = 29'h0000000,
    parameter int          DEPTH_WORDS = 512
) (
    input  logic        clock,
    input  logic        reset,

    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [5:0]  auto_in_a_bits_source,
    input  logic [28:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,

    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [5:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);

    localparam int          IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] WINDOW_BYTES = 30'(DEPTH_WORDS) << 3;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_ARITHMETIC  = 3'd2;
    localparam logic [2:0] A_LOGICAL     = 3'd3;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] A_HINT        = 3'd5;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK        = 3'd2;

    // Word storage; deliberately never reset.
    logic [63:0] mem [DEPTH_WORDS];

    // Single response register.
    logic        d_valid_q;
    logic [2:0]  d_opcode_q;
    logic [2:0]  d_size_q;
    logic [5:0]  d_source_q;
    logic        d_denied_q;
    logic [63:0] d_data_q;
    logic        d_corrupt_q;

    // Request decode.
    logic [29:0]      offset;
    logic             in_range;
    logic             aligned;
    logic             legal;
    logic [IDX_W-1:0] word_idx;
    logic             accept;
    logic             wr_en;

    // Response contents computed from the current A beat.
    logic [2:0]  nx_opcode;
    logic        nx_denied;
    logic [63:0] nx_data;
    logic        nx_corrupt;
    logic        nx_write;

    // a_param carries no meaning for this manager.
    logic unused_a_param;
    assign unused_a_param = ^auto_in_a_bits_param;

    // Ready whenever the response slot is empty or is being drained this cycle.
    assign auto_in_a_ready = !d_valid_q || auto_in_d_ready;

    // Reset edges never accept a beat, even if ready happens to be high.
    assign accept = auto_in_a_valid && auto_in_a_ready && !reset;
    assign wr_en  = accept && nx_write;

    assign offset   = {1'b0, auto_in_a_bits_address} - {1'b0, BASE_ADDR};
    assign in_range = (auto_in_a_bits_address >= BASE_ADDR) && (offset < WINDOW_BYTES);
    assign word_idx = offset[IDX_W+2:3];
    assign legal    = in_range && (auto_in_a_bits_size <= 3'd3) && aligned;

    // Address must be naturally aligned to the transfer size.
    always_comb begin
        aligned = 1'b0;
        case (auto_in_a_bits_size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = (auto_in_a_bits_address[0] == 1'b0);
            3'd2:    aligned = (auto_in_a_bits_address[1:0] == 2'b00);
            3'd3:    aligned = (auto_in_a_bits_address[2:0] == 3'b000);
            default: aligned = 1'b0;
        endcase
    end

    // Opcode dispatch: choose the D response and whether storage is written.
    always_comb begin
        nx_opcode  = D_ACCESS_ACK;
        nx_denied  = 1'b0;
        nx_data    = 64'd0;
        nx_corrupt = 1'b0;
        nx_write   = 1'b0;
        case (auto_in_a_bits_opcode)
            A_GET: begin
                nx_opcode = D_ACCESS_ACK_DATA;
                if (legal) begin
                    nx_data = mem[word_idx];
                end else begin
                    nx_denied  = 1'b1;
                    nx_corrupt = 1'b1;
                end
            end
            A_PUT_FULL, A_PUT_PARTIAL: begin
                nx_opcode = D_ACCESS_ACK;
                if (legal) begin
                    // Corrupt payloads are acknowledged but dropped.
                    nx_write = !auto_in_a_bits_corrupt;
                end else begin
                    nx_denied = 1'b1;
                end
            end
            A_ARITHMETIC, A_LOGICAL: begin
                nx_opcode  = D_ACCESS_ACK_DATA;
                nx_denied  = 1'b1;
                nx_corrupt = 1'b1;
            end
            A_HINT: begin
                nx_opcode = D_HINT_ACK;
            end
            default: begin
                nx_opcode = D_ACCESS_ACK;
                nx_denied = 1'b1;
            end
        endcase
    end

    // Byte-masked write at the acceptance edge, so a Get on the next cycle sees it.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (auto_in_a_bits_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
                end
            end
        end
    end

    // Response register: load on accept, clear on drain, hold while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            d_valid_q   <= 1'b0;
            d_opcode_q  <= 3'd0;
            d_size_q    <= 3'd0;
            d_source_q  <= 6'd0;
            d_denied_q  <= 1'b0;
            d_data_q    <= 64'd0;
            d_corrupt_q <= 1'b0;
        end else if (accept) begin
            d_valid_q   <= 1'b1;
            d_opcode_q  <= nx_opcode;
            d_size_q    <= auto_in_a_bits_size;
            d_source_q  <= auto_in_a_bits_source;
            d_denied_q  <= nx_denied;
            d_data_q    <= nx_data;
            d_corrupt_q <= nx_corrupt;
        end else if (auto_in_d_ready) begin
            d_valid_q   <= 1'b0;
        end
    end

    assign auto_in_d_valid        = d_valid_q;
    assign auto_in_d_bits_opcode  = d_opcode_q;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = d_size_q;
    assign auto_in_d_bits_source  = d_source_q;
    assign auto_in_d_bits_sink    = 1'b0;
    assign auto_in_d_bits_denied  = d_denied_q;
    assign auto_in_d_bits_data    = d_data_q;
    assign auto_in_d_bits_corrupt = d_corrupt_q;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// tb/tb_tl_ul_sram_responder.sv - scoreboard bench for tl_ul_sram_responder
module tb_tl_ul_sram_responder;

    localparam logic [28:0] BASE  = 29'h0001_0000;
    localparam int          DEPTH = 512;
    localparam int          IW    = $clog2(DEPTH);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_ready;
    logic        a_valid = 1'b0;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [2:0]  a_size = '0;
    logic [5:0]  a_source = '0;
    logic [28:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        a_corrupt = 1'b0;
    logic        d_ready = 1'b1;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [5:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [2:0]  size;
        logic [5:0]  source;
        logic        sink;
        logic        denied;
        logic        corrupt;
        logic [63:0] data;
    } d_beat_t;

    d_beat_t     exp_q[$];
    logic [63:0] ref_mem [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_beats = 0;

    always #5 clock = ~clock;

    tl_ul_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .auto_in_a_ready(a_ready),
        .auto_in_a_valid(a_valid),
        .auto_in_a_bits_opcode(a_opcode),
        .auto_in_a_bits_param(a_param),
        .auto_in_a_bits_size(a_size),
        .auto_in_a_bits_source(a_source),
        .auto_in_a_bits_address(a_address),
        .auto_in_a_bits_mask(a_mask),
        .auto_in_a_bits_data(a_data),
        .auto_in_a_bits_corrupt(a_corrupt),
        .auto_in_d_ready(d_ready),
        .auto_in_d_valid(d_valid),
        .auto_in_d_bits_opcode(d_opcode),
        .auto_in_d_bits_param(d_param),
        .auto_in_d_bits_size(d_size),
        .auto_in_d_bits_source(d_source),
        .auto_in_d_bits_sink(d_sink),
        .auto_in_d_bits_denied(d_denied),
        .auto_in_d_bits_data(d_data),
        .auto_in_d_bits_corrupt(d_corrupt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic d_beat_t obs_beat();
        return {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data};
    endfunction

    // Reference behaviour of the responder, applied once per accepted A beat.
    function automatic d_beat_t model(input logic [2:0] op, input logic [2:0] size,
                                      input logic [5:0] src, input logic [28:0] addr,
                                      input logic [7:0] mask, input logic [63:0] data,
                                      input logic corrupt);
        d_beat_t     r;
        int unsigned a;
        int unsigned b;
        logic        inr;
        logic        legal;
        logic [IW-1:0] idx;
        a     = 32'(addr);
        b     = 32'(BASE);
        inr   = (a >= b) && ((a - b) < 32'(8 * DEPTH));
        idx   = IW'((a - b) >> 3);
        legal = inr && (size <= 3'd3) && ((a & ((32'd1 << size) - 32'd1)) == 32'd0);
        r        = '0;
        r.size   = size;
        r.source = src;
        case (op)
            3'd4: begin
                r.opcode = 3'd1;
                if (legal) r.data = ref_mem[idx];
                else begin r.denied = 1'b1; r.corrupt = 1'b1; end
            end
            3'd0, 3'd1: begin
                r.opcode = 3'd0;
                if (!legal) r.denied = 1'b1;
                else if (!corrupt) begin
                    for (int i = 0; i < 8; i++)
                        if (mask[i]) ref_mem[idx][8*i +: 8] = data[8*i +: 8];
                end
            end
            3'd2, 3'd3: begin
                r.opcode = 3'd1; r.denied = 1'b1; r.corrupt = 1'b1;
            end
            3'd5: r.opcode = 3'd2;
            default: begin r.opcode = 3'd0; r.denied = 1'b1; end
        endcase
        return r;
    endfunction

    // Scoreboard: pop and compare each D handshake, push expectation for each A handshake.
    always @(negedge clock) begin
        d_beat_t e;
        if (!reset && d_valid && d_ready) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                check($sformatf("unexpected_d_beat%0d", n_beats), 128'(d_valid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check($sformatf("d_beat%0d", n_beats), 128'(obs_beat()), 128'(e));
            end
        end
        if (!reset && a_valid && a_ready)
            exp_q.push_back(model(a_opcode, a_size, a_source, a_address, a_mask, a_data, a_corrupt));
    end

    task automatic drive(input logic [2:0] op, input logic [2:0] size, input logic [5:0] src,
                         input logic [28:0] addr, input logic [7:0] mask, input logic [63:0] data,
                         input logic corrupt);
        a_opcode = op; a_size = size; a_source = src; a_address = addr;
        a_mask = mask; a_data = data; a_corrupt = corrupt; a_param = 3'd7; a_valid = 1'b1;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [5:0] src,
                        input logic [28:0] addr, input logic [7:0] mask, input logic [63:0] data,
                        input logic corrupt);
        bit done = 1'b0;
        drive(op, size, src, addr, mask, data, corrupt);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            done = a_ready;
            @(posedge clock);
            #1;
        end
        if (!done) check("send_timeout", 128'(a_ready), 128'(1));
        a_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        d_beat_t dummy;

        // Reset state
        reset = 1'b1; d_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_d_valid", 128'(d_valid), 128'(0));
        check("reset_d_fields", 128'(obs_beat()), 128'(0));
        check("reset_a_ready", 128'(a_ready), 128'(1));

        // Full write then immediate read of the same word
        send(3'd0, 3'd3, 6'd5, BASE + 29'h10, 8'hFF, 64'h0123456789ABCDEF, 1'b0);
        send(3'd4, 3'd3, 6'd6, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        // Partial write of the low half
        send(3'd1, 3'd3, 6'd1, BASE + 29'h10, 8'h0F, 64'hFFFFFFFF_00000000, 1'b0);
        send(3'd4, 3'd3, 6'd2, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        // Out of range and misaligned reads
        send(3'd4, 3'd3, 6'd3, BASE + 29'(8 * DEPTH), 8'hFF, 64'h0, 1'b0);
        send(3'd4, 3'd2, 6'd4, BASE + 29'h2, 8'h0F, 64'h0, 1'b0);
        send(3'd4, 3'd3, 6'd4, BASE - 29'h8, 8'hFF, 64'h0, 1'b0);
        // Illegal and corrupt puts must leave storage alone
        send(3'd0, 3'd3, 6'd9, BASE + 29'h14, 8'hFF, 64'hDEADBEEF_DEADBEEF, 1'b0);
        send(3'd0, 3'd4, 6'd9, BASE + 29'h10, 8'hFF, 64'hDEADBEEF_DEADBEEF, 1'b0);
        send(3'd0, 3'd3, 6'd9, BASE + 29'h10, 8'hFF, 64'hDEADBEEF_DEADBEEF, 1'b1);
        send(3'd0, 3'd3, 6'd9, BASE + 29'(8 * DEPTH), 8'hFF, 64'hDEADBEEF_DEADBEEF, 1'b0);
        send(3'd4, 3'd3, 6'd10, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        // Single-byte put, last word of the window
        send(3'd1, 3'd0, 6'd11, BASE + 29'h13, 8'h08, 64'h00000000_AB000000, 1'b0);
        send(3'd0, 3'd3, 6'd12, BASE + 29'(8 * DEPTH - 8), 8'hFF, 64'hCAFEF00D_12345678, 1'b0);
        send(3'd4, 3'd3, 6'd13, BASE + 29'(8 * DEPTH - 8), 8'hFF, 64'h0, 1'b0);
        send(3'd4, 3'd3, 6'd14, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        // Unsupported atomics, hint, reserved opcodes
        send(3'd2, 3'd3, 6'd15, BASE + 29'h10, 8'hFF, 64'h5555_5555_5555_5555, 1'b0);
        send(3'd3, 3'd3, 6'd16, BASE + 29'h10, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        send(3'd5, 3'd3, 6'd17, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        send(3'd6, 3'd3, 6'd18, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        send(3'd7, 3'd3, 6'd19, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        send(3'd4, 3'd3, 6'd20, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        drain();

        // Back-pressure: response held stable, A stalled
        d_ready = 1'b0;
        send(3'd4, 3'd3, 6'd21, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        drive(3'd4, 3'd3, 6'd22, BASE + 29'(8 * DEPTH - 8), 8'hFF, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("stall_d_valid%0d", i), 128'(d_valid), 128'(1));
            check($sformatf("stall_a_ready%0d", i), 128'(a_ready), 128'(0));
            check($sformatf("stall_fields%0d", i), 128'(obs_beat()), 128'(exp_q[0]));
            @(posedge clock);
            #1;
        end
        d_ready = 1'b1;
        send(3'd4, 3'd3, 6'd22, BASE + 29'(8 * DEPTH - 8), 8'hFF, 64'h0, 1'b0);
        check("burst_d_valid0", 128'(d_valid), 128'(1));
        send(3'd0, 3'd3, 6'd23, BASE + 29'h18, 8'hFF, 64'h1111_2222_3333_4444, 1'b0);
        check("burst_d_valid1", 128'(d_valid), 128'(1));
        send(3'd4, 3'd3, 6'd24, BASE + 29'h18, 8'hFF, 64'h0, 1'b0);
        check("burst_d_valid2", 128'(d_valid), 128'(1));
        drain();

        // Reset with a response pending; the A beat presented during reset is ignored
        d_ready = 1'b0;
        send(3'd4, 3'd3, 6'd25, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        check("pre_reset_d_valid", 128'(d_valid), 128'(1));
        drive(3'd0, 3'd3, 6'd26, BASE + 29'h10, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        a_valid = 1'b0;
        if (exp_q.size() != 0) dummy = exp_q.pop_front();
        check("post_reset_d_valid", 128'(d_valid), 128'(0));
        check("post_reset_d_fields", 128'(obs_beat()), 128'(0));
        check("post_reset_a_ready", 128'(a_ready), 128'(1));
        d_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        send(3'd4, 3'd3, 6'd27, BASE + 29'h10, 8'hFF, 64'h0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
